// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: MEM-stage load/store engine with request/ack handshake,
// byte-lane steering, load extension, misalignment detection and access timeout.
module data_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  MEM_RW,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] STORE_DATA,
    output logic        BUSY,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_ACK
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_error_q, bus_error_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic [2:0]  op;
    logic        is_store, is_half, is_word, misaligned;
    logic [3:0]  be;
    logic [31:0] wdata, rd_word, rd_ext;

    always_comb begin
        op         = MEM_RW[2:0];
        is_store   = (op == 3'b011) || (op[2:1] == 2'b11);
        is_half    = (op[1:0] == 2'b01) || (op == 3'b110);
        is_word    = (op == 3'b010) || (op == 3'b111);
        misaligned = (is_half && ADDRESS[0]) || (is_word && (ADDRESS[1:0] != 2'b00));
        be         = !is_store ? 4'b0000 :
                     is_word   ? 4'b1111 :
                     is_half   ? (ADDRESS[1] ? 4'b1100 : 4'b0011) :
                                 4'b0001 << ADDRESS[1:0];
        wdata      = !is_store ? 32'h0 :
                     is_word   ? STORE_DATA :
                     is_half   ? {2{STORE_DATA[15:0]}} :
                                 {4{STORE_DATA[7:0]}};
        rd_word    = MEM_READDATA >> {lane_q, 3'b000};
        rd_ext     = (op_q == 3'b000) ? {{24{rd_word[7]}}, rd_word[7:0]} :
                     (op_q == 3'b100) ? {24'h0, rd_word[7:0]} :
                     (op_q == 3'b001) ? {{16{rd_word[15]}}, rd_word[15:0]} :
                     (op_q == 3'b101) ? {16'h0, rd_word[15:0]} :
                                        MEM_READDATA;
    end

    // Nothing is accepted while reset is held, so BUSY/MISALIGNED stay low then.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        load_data_d = load_data_q;
        bus_error_d = 1'b0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        BUSY        = 1'b0;
        MISALIGNED  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MEM_RW[3] && RESET) begin
                    if (misaligned) begin
                        MISALIGNED = 1'b1;
                    end else begin
                        BUSY        = 1'b1;
                        op_d        = op;
                        lane_d      = ADDRESS[1:0];
                        mem_addr_d  = {ADDRESS[31:2], 2'b00};
                        mem_wdata_d = wdata;
                        mem_be_d    = be;
                        mem_read_d  = !is_store;
                        mem_write_d = is_store;
                        cnt_d       = 16'h0;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (MEM_ACK) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    load_data_d = mem_read_q ? rd_ext : load_data_q;
                    state_d     = S_DONE;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = mem_read_q ? 32'h0 : load_data_q;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'h0;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            load_data_q <= 32'h0;
            bus_error_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign LOAD_DATA     = load_data_q;
    assign BUS_ERROR     = bus_error_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign MEM_BYTE_EN   = mem_be_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed and random accesses against a size/offset
// based reference model of the memory access unit.
module tb_data_mem_access_unit;
    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [3:0]  MEM_RW = 4'h0;
    logic [31:0] ADDRESS = 32'h0;
    logic [31:0] STORE_DATA = 32'h0;
    logic        BUSY;
    logic [31:0] LOAD_DATA;
    logic        MISALIGNED;
    logic        BUS_ERROR;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_ACK = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] ld_model = 32'h0;

    data_mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_RW(MEM_RW), .ADDRESS(ADDRESS),
        .STORE_DATA(STORE_DATA), .BUSY(BUSY), .LOAD_DATA(LOAD_DATA),
        .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        if (op == 3'b010 || op == 3'b111) return 4;
        if (op == 3'b001 || op == 3'b101 || op == 3'b110) return 2;
        return 1;
    endfunction

    function automatic bit is_st(input logic [2:0] op);
        return op == 3'b011 || op == 3'b110 || op == 3'b111;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input int a, input logic [31:0] rd);
        int sz;
        logic [31:0] v, mask;
        sz = size_of(op);
        if (sz == 4) return rd;
        v = rd >> (8 * a);
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v = v & mask;
        if (!op[2] && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    // Entered and left in IDLE, a couple of ns after a rising edge.
    task automatic access(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rd);
        int sz, a, exp_w, req_obs, busy_obs;
        bit st, mis, tmo;
        sz = size_of(rw[2:0]);
        st = is_st(rw[2:0]);
        a = int'(addr[1:0]);
        mis = (a % sz) != 0;
        tmo = ack_at >= T;
        exp_w = tmo ? T : ack_at + 1;
        MEM_RW = rw; ADDRESS = addr; STORE_DATA = sd; MEM_READDATA = rd; MEM_ACK = 1'b0;
        #1;
        chk("misaligned", MISALIGNED, mis);
        chk("busy_idle", BUSY, !mis);
        busy_obs = BUSY;
        if (mis) begin
            @(posedge CLK); #2;
            chk("mis_no_req", {MEM_READ, MEM_WRITE, BUSY}, 0);
            chk("mis_stays_idle", MISALIGNED, 1);
            chk("mis_load_hold", LOAD_DATA, ld_model);
            MEM_RW = 4'h0; #1;
            chk("mis_clear", MISALIGNED, 0);
            return;
        end
        @(posedge CLK); #2;
        chk("req_addr", MEM_ADDR, addr & ~32'h3);
        chk("req_be", MEM_BYTE_EN, st ? (((1 << sz) - 1) << a) : 0);
        if (st)
            chk("req_wdata", MEM_WRITEDATA,
                sz == 4 ? sd : sz == 2 ? sd[15:0] * 32'h00010001 : sd[7:0] * 32'h01010101);
        req_obs = 0;
        for (int k = 0; k < T; k++) begin
            chk("wait_req", {MEM_READ, MEM_WRITE}, st ? 2'b01 : 2'b10);
            busy_obs += int'(BUSY);
            req_obs += int'(MEM_READ | MEM_WRITE);
            MEM_ACK = (k == ack_at);
            @(posedge CLK); #2;
            MEM_ACK = 1'b0;
            if (k == ack_at) break;
        end
        if (!st) ld_model = tmo ? 32'h0 : exp_load(rw[2:0], a, rd);
        chk("done_busy", BUSY, 0);
        chk("done_req", {MEM_READ, MEM_WRITE}, 0);
        chk("bus_error", BUS_ERROR, tmo);
        chk("load_data", LOAD_DATA, ld_model);
        chk("req_cycles", req_obs, exp_w);
        chk("busy_cycles", busy_obs, exp_w + 1);
        @(posedge CLK); #2;
        chk("idle_no_req", {MEM_READ, MEM_WRITE, BUS_ERROR}, 0);
        chk("load_hold", LOAD_DATA, ld_model);
        MEM_RW = 4'h0; #1;
        chk("idle_busy", BUSY, 0);
    endtask

    initial begin
        logic [3:0] rw;
        #12;
        chk("rst_load", LOAD_DATA, 0);
        chk("rst_flags", {BUS_ERROR, MEM_READ, MEM_WRITE, BUSY, MISALIGNED}, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_wdata", MEM_WRITEDATA, 0);
        chk("rst_be", MEM_BYTE_EN, 0);
        @(posedge CLK); #2;
        RESET = 1'b1;
        @(posedge CLK); #2;

        access(4'b1111, 32'h100, 32'hDEADBEEF, 1, 32'h0);
        access(4'b1000, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        chk("lb_literal", LOAD_DATA, 32'hFFFFFF80);
        access(4'b1100, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        chk("lbu_literal", LOAD_DATA, 32'h00000080);
        access(4'b1110, 32'h102, 32'h1234ABCD, 0, 32'h0);
        access(4'b1101, 32'h102, 32'h0, 0, 32'hF00D0000);
        chk("lhu_literal", LOAD_DATA, 32'h0000F00D);
        access(4'b1010, 32'h101, 32'h0, 0, 32'h55555555);
        access(4'b1010, 32'h200, 32'h0, 99, 32'h12345678);
        chk("timeout_literal", LOAD_DATA, 32'h0);
        access(4'b1010, 32'h200, 32'h0, 3, 32'h12345678);
        chk("late_ack_literal", LOAD_DATA, 32'h12345678);

        for (int i = 0; i < 40; i++) begin
            rw = {1'b1, 3'($urandom_range(0, 7))};
            access(rw, $urandom, $urandom, $urandom_range(0, 5), $urandom);
        end

        MEM_ACK = 1'b1; MEM_READDATA = $urandom;
        @(posedge CLK); #2;
        MEM_ACK = 1'b0;
        chk("idle_ack_ignored", {BUSY, MEM_READ, MEM_WRITE, BUS_ERROR}, 0);
        chk("idle_ack_load", LOAD_DATA, ld_model);

        MEM_RW = 4'b1010; ADDRESS = 32'h300; MEM_READDATA = 32'h0;
        @(posedge CLK); #2;
        chk("rst_pre_req", {MEM_READ, BUSY}, 2'b11);
        RESET = 1'b0; #1;
        chk("rst_drop", {MEM_READ, MEM_WRITE, BUSY}, 0);
        ld_model = 32'h0;
        chk("rst_load_clr", LOAD_DATA, 0);
        MEM_RW = 4'h0;
        @(posedge CLK); #2;
        RESET = 1'b1; MEM_ACK = 1'b1; MEM_READDATA = 32'hFFFFFFFF;
        @(posedge CLK); #2;
        MEM_ACK = 1'b0;
        chk("post_rst_ack_ignored", {BUSY, MEM_READ, BUS_ERROR}, 0);
        chk("post_rst_load", LOAD_DATA, 0);
        access(4'b1010, 32'h300, 32'h0, 0, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
